alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational `alu` instance between two requesters, e.g. the execute stage (port 0) and the address/branch-compare unit (port 1).
- Arbitrates round-robin with a valid/ready request handshake per port.
- Registers the ALU output into a single response stage and returns it to the owning requester with valid/ready.
- Provides a one-cycle-latency, back-pressure-aware front end to the shared ALU.

Parameters:
DATA_WIDTH, 32, operand/result width passed to the `alu` instance
FIXED_PRIORITY, 0, 0 = round-robin arbitration; 1 = port 0 always wins conflicts

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  2  per-port request valid
req_ready  out  2  per-port request accepted this cycle
req_a  in  2xDATA_WIDTH  operand A, one per port
req_b  in  2xDATA_WIDTH  operand B, one per port
req_ctl  in  2x4  ALU control code per port (`alu.vh` encoding)
rsp_valid  out  2  response valid, at most one bit set
rsp_ready  in  2  per-port response consumed
rsp_result  out  DATA_WIDTH  registered ALU result (shared by both ports)
rsp_zero  out  1  registered ALU Zero flag
rsp_owner  out  1  index of the port owning the current response

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-high.
- State machine: two states.
  - EMPTY: no response is held.
  - FULL: a response is held, owned by `owner_q`.
- can_accept = EMPTY, or (FULL and `rsp_ready[owner_q]`). Draining and accepting in the same cycle is allowed, giving full throughput.
- Grant rules:
  - Only one port valid: that port is granted.
  - Both valid, FIXED_PRIORITY=0: grant the port != `last_q`.
  - Both valid, FIXED_PRIORITY=1: grant port 0.
  - Neither valid: no grant.
- `req_ready[i]` = can_accept and grant==i. It is combinational in `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- ALU operand mux: A, B and ALUCtl are taken from the granted port. With no grant they come from port 0; the result is then unused.
- On accept (rising edge):
  - `result_q` <= ALU Result; `zero_q` <= ALU Zero.
  - `owner_q` <= grant; `last_q` <= grant.
  - State -> FULL.
- On drain without accept: state -> EMPTY; `result_q` and `zero_q` hold their values.
- FULL and owner not ready: hold everything; both `req_ready` bits are 0.
- Outputs:
  - `rsp_valid[i]` = FULL and `owner_q`==i.
  - `rsp_result` = `result_q`; `rsp_zero` = `zero_q`; `rsp_owner` = `owner_q`.
- Latency: exactly 1 cycle from the accept edge to `rsp_valid`. Throughput: 1 op/cycle while the consumer is ready.
- Fairness: with FIXED_PRIORITY=0 and both ports continuously valid, grants strictly alternate. Neither port waits more than 1 accept slot.
- ALU control codes: passed through unmodified. Undefined codes (e.g. 4'hF) yield result 0 and Zero 1 from the ALU, and are registered as-is.
- Arithmetic: no width changes. Wrap-around is the ALU's; e.g. FFFF_FFFF+1 = 0 with Zero=1.
- Reset values: state EMPTY, `rsp_valid`=2'b00, `result_q`=0, `zero_q`=0, `owner_q`=0, `last_q`=1 (port 0 wins the first conflict).
- Reset mid-operation: a held response is discarded. No `rsp_valid` is asserted until a new accept after reset deasserts.

Decomposition:
- Shared package `alu_pkg`:
  - ALU control codes, moved from `alu.vh` as a localparam enum `alu_ctl_t` (ALU_ADD etc.).
  - Port-count constant `ALU_NUM_REQ`=2.
  - Arbiter state typedef {EMPTY, FULL}.
- Sub-module: the existing `alu` instanced once (DATA_WIDTH passed through). The arbiter itself is a single module, with no further split.

Test Plan:
- Single request: port 0 sends A=1, B=2, ALU_ADD.
  - Same cycle: `req_ready`=01.
  - Next cycle: `rsp_valid`=01, result=3, zero=0, owner=0.
- Conflict: both ports valid for 4 cycles, rsp_ready=11. Port 0 sends 20+0, port 1 sends FFFF_FFFF+1.
  - Grants must be 0,1,0,1.
  - Responses alternate: 20/zero 0, then 0/zero 1.
- Back-pressure: response held for port 1 with `rsp_ready[1]`=0 for 3 cycles while port 0 is valid.
  - `req_ready`=00 and result stable for those 3 cycles.
  - On the ready cycle, port 0 is accepted in the same cycle (drain+accept).
- Undefined control: A=1234_5678, B=8765_4321, ctl=4'hF -> result 0000_0000, zero=1 after 1 cycle.
- FIXED_PRIORITY=1: both ports valid for 3 cycles -> port 0 granted every cycle; `req_ready[1]`=0 throughout.
- Async reset while FULL: assert `rst` mid-cycle.
  - `rsp_valid` goes to 00 immediately, without waiting for a clock edge.
  - After release, the first conflict grants port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions.
//   alu_ctl_t   : ALU control codes (4-bit encoding used by req_ctl / ALUCtl)
//   ALU_NUM_REQ : number of requesters sharing the ALU
//   arb_state_t : response-stage state of the sharing arbiter
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7,
    ALU_NOR = 4'hC
  } alu_ctl_t;

  localparam int unsigned ALU_NUM_REQ = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   ALUCtl : control code (alu_ctl_t encoding); undefined codes give 0
//   A, B   : operands, DATA_WIDTH bits
//   ALUOut : result, wraps at DATA_WIDTH bits
//   Zero   : 1 when ALUOut is all zeros
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [3:0]            ALUCtl,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] ALUOut,
  output logic                  Zero
);

  always_comb begin
    ALUOut = '0;
    case (ALUCtl)
      ALU_AND: ALUOut = A & B;
      ALU_OR:  ALUOut = A | B;
      ALU_ADD: ALUOut = A + B;
      ALU_SUB: ALUOut = A - B;
      ALU_SLT: ALUOut = {{(DATA_WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_NOR: ALUOut = ~(A | B);
      default: ALUOut = '0;
    endcase
  end

  assign Zero = (ALUOut == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters.
// Requests are arbitrated (round-robin or fixed priority), the ALU result is
// registered into a single response stage and returned to the owning port.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req_valid  : per-port request valid
//   req_ready  : per-port request accepted this cycle (combinational)
//   req_a/b    : per-port operands, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ctl    : per-port ALU control, port i at [i*4 +: 4]
//   rsp_valid  : per-port response valid, at most one bit set
//   rsp_ready  : per-port response consumed
//   rsp_result : registered ALU result
//   rsp_zero   : registered ALU Zero flag
//   rsp_owner  : port owning the current response
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ALU_NUM_REQ-1:0]            req_valid,
  output logic [ALU_NUM_REQ-1:0]            req_ready,
  input  logic [ALU_NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [ALU_NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [ALU_NUM_REQ*4-1:0]          req_ctl,
  output logic [ALU_NUM_REQ-1:0]            rsp_valid,
  input  logic [ALU_NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]             rsp_result,
  output logic                              rsp_zero,
  output logic                              rsp_owner
);

  arb_state_t                r_state;
  logic [ALU_NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0]     r_result;
  logic                      r_zero;
  logic                      r_owner;
  logic                      r_last;

  logic                      w_any_req;
  logic                      w_gnt;
  logic                      w_can_accept;
  logic                      w_accept;
  logic [DATA_WIDTH-1:0]     w_a;
  logic [DATA_WIDTH-1:0]     w_b;
  logic [3:0]                w_ctl;
  logic [DATA_WIDTH-1:0]     w_alu_result;
  logic                      w_alu_zero;

  always_comb begin
    w_any_req = |req_valid;
    // With a single (or no) requester the grant is simply req_valid[1];
    // when nothing is valid this selects port 0 for the unused ALU inputs.
    if (req_valid == 2'b11) begin
      w_gnt = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last;
    end else begin
      w_gnt = req_valid[1];
    end
    // A held response may drain in the same cycle a new one is accepted.
    w_can_accept = (r_state == EMPTY) || rsp_ready[r_owner];
    w_accept     = w_can_accept && w_any_req;
    req_ready    = '0;
    if (w_accept) begin
      req_ready[w_gnt] = 1'b1;
    end
    w_a   = w_gnt ? req_a[DATA_WIDTH +: DATA_WIDTH] : req_a[0 +: DATA_WIDTH];
    w_b   = w_gnt ? req_b[DATA_WIDTH +: DATA_WIDTH] : req_b[0 +: DATA_WIDTH];
    w_ctl = w_gnt ? req_ctl[7:4] : req_ctl[3:0];
  end

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .ALUCtl(w_ctl),
    .A     (w_a),
    .B     (w_b),
    .ALUOut(w_alu_result),
    .Zero  (w_alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_rsp_valid <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
    end else if (w_accept) begin
      r_state     <= FULL;
      r_rsp_valid <= w_gnt ? 2'b10 : 2'b01;
      r_result    <= w_alu_result;
      r_zero      <= w_alu_zero;
      r_owner     <= w_gnt;
      r_last      <= w_gnt;
    end else if ((r_state == FULL) && rsp_ready[r_owner]) begin
      r_state     <= EMPTY;
      r_rsp_valid <= '0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_owner  = r_owner;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic [7:0]      req_ctl;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic            rsp_owner;

  logic [1:0]      fp_req_ready;
  logic [1:0]      fp_rsp_valid;
  logic [1:0]      fp_rsp_ready;
  logic [DW-1:0]   fp_rsp_result;
  logic            fp_rsp_zero;
  logic            fp_rsp_owner;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] result;
    logic          zero;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic tb_last;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_owner(rsp_owner)
  );

  alu_share_arbiter #(.DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_owner(fp_rsp_owner)
  );

  assign fp_rsp_ready = 2'b11;

  // Reference ALU: literal encodings, independent of the RTL case statement.
  function automatic rsp_t model(input logic owner, input logic [3:0] ctl,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    rsp_t r;
    r.owner = owner;
    case (ctl)
      4'h0:    r.result = a & b;
      4'h1:    r.result = a | b;
      4'h2:    r.result = a + b;
      4'h6:    r.result = a - b;
      4'hC:    r.result = ~(a | b);
      default: r.result = '0;
    endcase
    r.zero = (r.result == '0);
    return r;
  endfunction

  task automatic set_port(input int p, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [3:0] c);
    req_a[p*DW +: DW] = a;
    req_b[p*DW +: DW] = b;
    req_ctl[p*4 +: 4] = c;
  endtask

  // Scoreboard: a response is compared when its handshake completes.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      checks++;
      if (rsp_valid === 2'b11) begin
        errors++;
        $display("FAIL rsp_onehot: rsp_valid=%b required at most one bit", rsp_valid);
      end
      if (|(rsp_valid & rsp_ready)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rsp_valid=%b result=%h with nothing expected",
                   rsp_valid, rsp_result);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          if (rsp_owner !== e.owner || rsp_result !== e.result || rsp_zero !== e.zero ||
              rsp_valid !== (e.owner ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL sb_rsp: got owner=%0d result=%h zero=%b valid=%b, required owner=%0d result=%h zero=%b",
                     rsp_owner, rsp_result, rsp_zero, rsp_valid, e.owner, e.result, e.zero);
          end
        end
      end
    end
  end

  task automatic idle_drain(input string name);
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: rsp_valid=%b pending=%0d, required 00 and 0", name, rsp_valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_ctl = '0;
    tb_last = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_result !== '0 || rsp_zero !== 1'b0 ||
        rsp_owner !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h zero=%b owner=%b req_ready=%b, required 00/0/0/0/00",
               rsp_valid, rsp_result, rsp_zero, rsp_owner, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_conflict();
    for (int k = 0; k < 4; k++) begin
      logic g;
      @(negedge clk);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_port(0, 32'd20, 32'd0, ALU_ADD);
      set_port(1, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
      #1;
      g = k[0];
      checks++;
      if (req_ready !== (g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL conflict_grant%0d: req_ready=%b required %b", k, req_ready, g ? 2'b10 : 2'b01);
      end
      if (g) sb.push_back(model(1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1));
      else   sb.push_back(model(1'b0, ALU_ADD, 32'd20, 32'd0));
      tb_last = g;
    end
    idle_drain("conflict");
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    set_port(0, 32'd1, 32'd2, ALU_ADD);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_req_ready: req_ready=%b required 01", req_ready);
    end
    sb.push_back(model(1'b0, ALU_ADD, 32'd1, 32'd2));
    tb_last = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd3 || rsp_zero !== 1'b0 || rsp_owner !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b result=%h zero=%b owner=%b, required 01/3/0/0",
               rsp_valid, rsp_result, rsp_zero, rsp_owner);
    end
    idle_drain("single");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    set_port(1, 32'd7, 32'd3, ALU_SUB);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_first_ready: req_ready=%b required 10", req_ready);
    end
    sb.push_back(model(1'b1, ALU_SUB, 32'd7, 32'd3));
    tb_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      set_port(0, 32'd100, 32'd23, ALU_ADD);
      #1;
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b10 || rsp_result !== 32'd4) begin
        errors++;
        $display("FAIL bp_hold%0d: req_ready=%b valid=%b result=%h, required 00/10/4",
                 k, req_ready, rsp_valid, rsp_result);
      end
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_drain_accept: req_ready=%b required 01", req_ready);
    end
    sb.push_back(model(1'b0, ALU_ADD, 32'd100, 32'd23));
    tb_last = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'd123) begin
      errors++;
      $display("FAIL bp_next_rsp: valid=%b result=%h required 01/7b", rsp_valid, rsp_result);
    end
    idle_drain("backpressure");
  endtask

  task automatic test_undefined_ctl();
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    set_port(0, 32'h1234_5678, 32'h8765_4321, 4'hF);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL undef_ready: req_ready=%b required 01", req_ready);
    end
    sb.push_back(model(1'b0, 4'hF, 32'h1234_5678, 32'h8765_4321));
    tb_last = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'h0000_0000 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL undef_rsp: valid=%b result=%h zero=%b, required 01/00000000/1",
               rsp_valid, rsp_result, rsp_zero);
    end
    idle_drain("undef");
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k < 3; k++) begin
      logic g;
      logic [DW-1:0] a0;
      a0 = 32'd50 + DW'(k);
      @(negedge clk);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_port(0, a0, 32'd5, ALU_SUB);
      set_port(1, 32'h00FF_0000, 32'h0000_FF00, ALU_OR);
      #1;
      checks++;
      if (fp_req_ready !== 2'b01) begin
        errors++;
        $display("FAIL fixed_grant%0d: req_ready=%b required 01", k, fp_req_ready);
      end
      if (k > 0) begin
        checks++;
        if (fp_rsp_valid !== 2'b01 || fp_rsp_owner !== 1'b0 || fp_rsp_result !== (a0 - 32'd6)) begin
          errors++;
          $display("FAIL fixed_rsp%0d: valid=%b owner=%b result=%h, required 01/0/%h",
                   k, fp_rsp_valid, fp_rsp_owner, fp_rsp_result, a0 - 32'd6);
        end
      end
      g = ~tb_last;
      checks++;
      if (req_ready !== (g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_alt%0d: req_ready=%b required %b", k, req_ready, g ? 2'b10 : 2'b01);
      end
      if (g) sb.push_back(model(1'b1, ALU_OR, 32'h00FF_0000, 32'h0000_FF00));
      else   sb.push_back(model(1'b0, ALU_SUB, a0, 32'd5));
      tb_last = g;
    end
    idle_drain("fixed");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    set_port(0, 32'd5, 32'd5, ALU_ADD);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL areset_held: rsp_valid=%b required 01", rsp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL areset_immediate: rsp_valid=%b required 00", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b1;
    rsp_ready = 2'b11;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL areset_discard: rsp_valid=%b required 00", rsp_valid);
    end
    @(negedge clk);
    req_valid = 2'b11;
    set_port(0, 32'd9, 32'd1, ALU_SUB);
    set_port(1, 32'd3, 32'd3, ALU_ADD);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL areset_first_grant: req_ready=%b required 01", req_ready);
    end
    sb.push_back(model(1'b0, ALU_SUB, 32'd9, 32'd1));
    tb_last = 1'b0;
    idle_drain("areset");
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_single();
    test_back_to_back();
    test_undefined_ctl();
    test_fixed_priority();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
